// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e : controller states (IDLE, RUN, DONE)
//   cnt_w() : width of the step counter for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter holds WIDTH-1 down to 0; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step, MSB first.
// Ports:
//   r_i  [WIDTH] partial remainder entering the step
//   q_i  [WIDTH] dividend/quotient shift register (MSB is the next dividend bit)
//   d_i  [WIDTH] divisor
//   r_o  [WIDTH] partial remainder after the step
//   q_o  [WIDTH] shift register with the new quotient bit in the LSB
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Shifted remainder needs one extra bit before the compare.
    wide = {r_i, q_i[WIDTH-1]};
    ge   = (wide >= {1'b0, d_i});
    // When ge holds the true difference is < d_i, so the low WIDTH bits
    // of the subtraction are exact and the carry-out can be dropped.
    diff = wide[WIDTH-1:0] - d_i;
    r_o  = ge ? diff : wide[WIDTH-1:0];
    q_o  = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle restoring unsigned divider with start/busy/done handshake.
// One quotient bit per clock; a result is ready WIDTH edges after accept.
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   start              request, honoured only in IDLE or DONE
//   dividend, divisor  operands, captured on the accepting edge
//   busy               high while iterating
//   done               one-cycle pulse; results valid from then on
//   quotient/remainder floor(a/b) and a mod b (held until next accept)
//   div_zero           captured divisor was zero
// Build option:
//   DIV_ZERO_SHORTCUT_EN  a zero divisor completes one edge after accept
//                         instead of running all WIDTH steps.
module seq_unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  import divider_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;   // partial remainder
  logic [WIDTH-1:0] q_q, q_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] d_q, d_d;
  logic             dz_q, dz_d;
  logic             accept;

  logic [WIDTH-1:0] r_step, q_step;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    dz_d    = dz_q;
    accept  = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: ;
      RUN: begin
`ifdef DIV_ZERO_SHORTCUT_EN
        if (dz_q) begin
          // q_q still holds the untouched dividend on the first RUN edge.
          r_d     = q_q;
          q_d     = '1;
          cnt_d   = '0;
          state_d = DONE;
        end else
`endif
        begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      q_d     = dividend;
      d_d     = divisor;
      r_d     = '0;
      dz_d    = (divisor == '0);
      cnt_d   = CW'(WIDTH - 1);
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
module tb_seq_unsigned_divider;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st8, st16;
  logic [7:0]  a8, b8, q8, r8;
  logic [15:0] a16, b16, q16, r16;
  logic        busy8, done8, dz8, busy16, done16, dz16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_unsigned_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8)
  );

  seq_unsigned_divider #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_zero(dz16)
  );

  // Reference: plain integer division; zero divisor gives all-ones / dividend.
  function automatic void ref_div(input int w, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz);
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    if (b == 16'd0) begin
      q = mask; r = a & mask; dz = 1'b1;
    end else begin
      q = (a & mask) / b; r = (a & mask) % b; dz = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input int w, input logic [15:0] b);
    return (SC && b == 16'd0) ? 1 : w;
  endfunction

  // Issue one division at the current negedge and wait for done.
  // lat = edges from accept to done (-1 on timeout); pulse_at re-pulses
  // start (with 9/2) so it is sampled at accept+pulse_at.
  task automatic run_div(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input int pulse_at,
                         output logic [15:0] q, output logic [15:0] r, output logic dz,
                         output int lat, output bit busy_ok, output bit early_ok);
    int n;
    if (wide) begin st16 = 1'b1; a16 = a; b16 = b; end
    else      begin st8  = 1'b1; a8  = a[7:0]; b8 = b[7:0]; end
    @(negedge clk);
    early_ok = wide ? (!done16 && busy16) : (!done8 && busy8);
    busy_ok  = 1'b1;
    lat      = -1;
    n        = 0;
    // Scramble operand inputs to show they were captured.
    if (wide) begin a16 = 16'($urandom); b16 = 16'($urandom); end
    else      begin a8  = 8'($urandom);  b8  = 8'($urandom);  end
    while (n < 40) begin
      if (n + 1 == pulse_at) begin
        if (wide) begin st16 = 1'b1; a16 = 16'd9; b16 = 16'd2; end
        else      begin st8  = 1'b1; a8  = 8'd9;  b8  = 8'd2;  end
      end else begin
        st8 = 1'b0; st16 = 1'b0;
      end
      @(negedge clk);
      n++;
      if (wide ? done16 : done8) begin
        lat = n;
        break;
      end
      if (!(wide ? busy16 : busy8)) busy_ok = 1'b0;
    end
    st8 = 1'b0; st16 = 1'b0;
    q  = wide ? q16 : {8'd0, q8};
    r  = wide ? r16 : {8'd0, r8};
    dz = wide ? dz16 : dz8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st8 = 1'b0; st16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy8, done8, q8, r8, dz8} !== 19'd0) begin
      n_err++;
      $display("FAIL reset8: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy8, done8, q8, r8, dz8);
    end
    n_vec++;
    if ({busy16, done16, q16, r16, dz16} !== 35'd0) begin
      n_err++;
      $display("FAIL reset16: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy16, done16, q16, r16, dz16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] q, r; logic dz; int lat; bit bok, eok;
    run_div(1'b0, 16'd100, 16'd7, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd14 || r !== 16'd2 || dz !== 1'b0 || lat != 8 || !bok || !eok) begin
      n_err++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b lat=%0d busy_ok=%b early_ok=%b, want 14 2 0 8 1 1",
               q, r, dz, lat, bok, eok);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || q8 !== 8'd14 || r8 !== 8'd2) begin
      n_err++;
      $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d, want 0 0 14 2",
               done8, busy8, q8, r8);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q, r; logic dz; int lat; bit bok, eok;
    run_div(1'b0, 16'd200, 16'd15, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd13 || r !== 16'd5 || dz !== 1'b0 || lat != 8) begin
      n_err++;
      $display("FAIL b2b_first: got q=%0d r=%0d dz=%b lat=%0d, want 13 5 0 8", q, r, dz, lat);
    end
    // Called in the DONE cycle: start is high while done is high.
    run_div(1'b0, 16'd255, 16'd3, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (!eok) begin
      n_err++;
      $display("FAIL b2b_done_drop: got early_ok=%b, want done=0 busy=1 after restart", eok);
    end
    n_vec++;
    if (q !== 16'd85 || r !== 16'd0 || dz !== 1'b0 || lat != 8 || !bok) begin
      n_err++;
      $display("FAIL b2b_second: got q=%0d r=%0d dz=%b lat=%0d busy_ok=%b, want 85 0 0 8 1",
               q, r, dz, lat, bok);
    end
    @(negedge clk);
    n_vec++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_pulse_width: got done=%b busy=%b, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r; logic dz; int lat; bit bok, eok;
    run_div(1'b0, 16'd37, 16'd0, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd255 || r !== 16'd37 || dz !== 1'b1 || lat != exp_lat(8, 16'd0)) begin
      n_err++;
      $display("FAIL div_zero: got q=%0d r=%0d dz=%b lat=%0d, want 255 37 1 %0d",
               q, r, dz, lat, exp_lat(8, 16'd0));
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [15:0] q, r; logic dz; int lat; bit bok, eok;
    run_div(1'b0, 16'd100, 16'd7, 3, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd14 || r !== 16'd2 || lat != 8 || !bok) begin
      n_err++;
      $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d busy_ok=%b, want 14 2 8 1",
               q, r, lat, bok);
    end
    @(negedge clk);
    n_vec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_queue: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    st8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(negedge clk);               // accept edge passed
    st8 = 1'b0;
    repeat (3) @(negedge clk);    // after accept+3
    rst_n = 1'b0;                 // sampled at accept+4
    @(negedge clk);
    n_vec++;
    if ({busy8, done8, q8, r8} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_abort: got busy=%b done=%b q=%0d r=%0d, want all 0",
               busy8, done8, q8, r8);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_abort_no_done: got done pulse after abort, want none");
    end
  endtask

  task automatic test_w16();
    logic [15:0] q, r; logic dz; int lat; bit bok, eok;
    run_div(1'b1, 16'd65535, 16'd255, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd257 || r !== 16'd0 || dz !== 1'b0 || lat != 16) begin
      n_err++;
      $display("FAIL w16_65535_255: got q=%0d r=%0d dz=%b lat=%0d, want 257 0 0 16", q, r, dz, lat);
    end
    @(negedge clk);
    run_div(1'b1, 16'd1000, 16'd1001, -1, q, r, dz, lat, bok, eok);
    n_vec++;
    if (q !== 16'd0 || r !== 16'd1000 || dz !== 1'b0 || lat != 16) begin
      n_err++;
      $display("FAIL w16_1000_1001: got q=%0d r=%0d dz=%b lat=%0d, want 0 1000 0 16", q, r, dz, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, eq, er; logic dz, edz; int lat; bit bok, eok, wide;
    for (int i = 0; i < 36; i++) begin
      wide = (i >= 24);
      a = wide ? 16'($urandom) : {8'd0, 8'($urandom)};
      if ($urandom_range(0, 5) == 0) b = 16'd0;
      else b = wide ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 255));
      ref_div(wide ? 16 : 8, a, b, eq, er, edz);
      run_div(wide, a, b, -1, q, r, dz, lat, bok, eok);
      n_vec++;
      if (q !== eq || r !== er || dz !== edz || lat != exp_lat(wide ? 16 : 8, b)) begin
        n_err++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dz=%b lat=%0d, want %0d %0d %b %0d",
                 i, a, b, q, r, dz, lat, eq, er, edz, exp_lat(wide ? 16 : 8, b));
      end
      // Alternate between idle gaps and back-to-back issue.
      if (i % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_w16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
